// File: rtl/adder_pkg.sv
// Shared opcode encodings and the per-stage chunk width derivation
// for the pipelined adder/subtractor.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple-carry adder slice; exposes per-bit generate/propagate
// alongside the sum and carry out.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carryin,
    output logic [CHUNK-1:0] sum,
    output logic             carryout,
    output logic [CHUNK-1:0] gen,
    output logic [CHUNK-1:0] prop
);

    logic [CHUNK:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        carry    = '0;
        carry[0] = carryin;
        for (int i = 0; i < CHUNK; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum      = prop ^ carry[CHUNK-1:0];
    assign carryout = carry[CHUNK];

endmodule

// File: rtl/pipelined_add_sub.sv
// Valid/ready pipelined adder/subtractor: one CHUNK-bit slice per stage,
// carry rippling between stages, whole pipe stalls while the output is held.
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    logic             advance;
    logic             cin;
    logic [WIDTH-1:0] b_mod;

    logic [WIDTH-1:0] op_a      [STAGES];
    logic [WIDTH-1:0] op_b      [STAGES];
    logic [WIDTH-1:0] prev_sum  [STAGES];
    logic [WIDTH-1:0] next_sum  [STAGES];
    logic             carry_in  [STAGES];
    logic             valid_in  [STAGES];
    logic [CHUNK-1:0] chunk_sum [STAGES];
    logic             chunk_cout[STAGES];
    logic [CHUNK-1:0] gen_bits  [STAGES];
    logic [CHUNK-1:0] prop_bits [STAGES];

    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             valid_q [STAGES];
    logic             overflow_q;
    logic             zero_q;
    logic             overflow_next;
    logic             zero_next;

    function automatic logic [WIDTH-1:0] insert_chunk(
        input logic [WIDTH-1:0] base,
        input logic [CHUNK-1:0] part,
        input int               idx
    );
        logic [WIDTH-1:0] r;
        r = base;
        r[idx*CHUNK +: CHUNK] = part;
        return r;
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign cin      = (sub == OP_SUB);
    assign b_mod    = cin ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic unused_gp;

        if (k == 0) begin : g_head
            assign op_a[k]     = a;
            assign op_b[k]     = b_mod;
            assign prev_sum[k] = '0;
            assign carry_in[k] = cin;
            assign valid_in[k] = in_valid;
        end else begin : g_tail
            assign op_a[k]     = a_q[k-1];
            assign op_b[k]     = b_q[k-1];
            assign prev_sum[k] = sum_q[k-1];
            assign carry_in[k] = carry_q[k-1];
            assign valid_in[k] = valid_q[k-1];
        end

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (op_a[k][k*CHUNK +: CHUNK]),
            .b        (op_b[k][k*CHUNK +: CHUNK]),
            .carryin  (carry_in[k]),
            .sum      (chunk_sum[k]),
            .carryout (chunk_cout[k]),
            .gen      (gen_bits[k]),
            .prop     (prop_bits[k])
        );

        assign next_sum[k] = insert_chunk(prev_sum[k], chunk_sum[k], k);
        assign unused_gp   = ^{gen_bits[k], prop_bits[k]};
    end

    // Flags are resolved while the last chunk is being added so they register with it.
    assign overflow_next = (op_a[STAGES-1][WIDTH-1] == op_b[STAGES-1][WIDTH-1]) &&
                           (next_sum[STAGES-1][WIDTH-1] != op_a[STAGES-1][WIDTH-1]);
    assign zero_next     = (next_sum[STAGES-1] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
            end
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_in[k];
                carry_q[k] <= chunk_cout[k];
                a_q[k]     <= op_a[k];
                b_q[k]     <= op_b[k];
                sum_q[k]   <= next_sum[k];
            end
            overflow_q <= overflow_next;
            zero_q     <= zero_next;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign carryout  = carry_q[STAGES-1];
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and randomized checks of pipelined_add_sub at WIDTH=8, STAGES=4.
module tb_pipelined_add_sub;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       carryout;
    logic       overflow;
    logic       zero;

    int n_vec  = 0;
    int n_miss = 0;

    logic [10:0] q[$];
    logic [7:0]  sa [6];
    logic [7:0]  sb [6];
    logic        ss [6];
    logic [7:0]  se [6];

    pipelined_add_sub #(.WIDTH(8), .STAGES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {overflow, zero, carryout, sum} from signed/unsigned integer arithmetic.
    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        int         sx;
        int         sy;
        int         r;
        logic [7:0] res;
        logic       c;
        logic       o;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r   = sx - sy;
            res = x - y;
            c   = (x >= y);
        end else begin
            r   = sx + sy;
            res = x + y;
            c   = (int'(x) + int'(y)) > 255;
        end
        o = (r > 127) || (r < -128);
        return {o, (res == 8'h00), c, res};
    endfunction

    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic s, input logic [10:0] exp);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        sub       = s;
        out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, exp[7:0]);
        check({tag, "_carry"}, carryout, exp[8]);
        check({tag, "_zero"}, zero, exp[9]);
        check({tag, "_ovf"}, overflow, exp[10]);
    endtask

    initial begin
        int          sent;
        int          got;
        int          stall_left;
        int          seen;
        int          n_in;
        int          n_out;
        logic        held;
        logic [10:0] held_val;
        logic [10:0] exp_v;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carryout, 0);
        check("rst_ovf", overflow, 0);
        check("rst_zero", zero, 0);
        reset = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        // {overflow, zero, carryout, sum}
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 1'b1, 8'h00});
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 1'b0, 8'h80});
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, {1'b1, 1'b0, 1'b1, 8'h7F});
        run_op("sub_05_05", 8'h05, 8'h05, 1'b1, {1'b0, 1'b1, 1'b1, 8'h00});
        run_op("sub_03_05", 8'h03, 8'h05, 1'b1, {1'b0, 1'b0, 1'b0, 8'hFE});

        // Six back-to-back ops with a 3-cycle output stall on the first result.
        sa = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        sb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        ss = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        se = '{8'h11, 8'h1E, 8'h33, 8'h3C, 8'h55, 8'h5A};
        sent       = 0;
        got        = 0;
        stall_left = -1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            if (stall_left < 0 && out_valid) stall_left = 3;
            out_ready = !(stall_left > 0);
            if (sent < 6) begin
                in_valid = 1'b1;
                a        = sa[sent];
                b        = sb[sent];
                sub      = ss[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_valid", out_valid, 1);
                check("stall_hold", sum, 8'h11);
                stall_left--;
            end
            if (out_valid && out_ready) begin
                check("order_sum", sum, se[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("stall_count", got, 6);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Reset with two ops in flight; an op offered during reset must also vanish.
        in_valid = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
        @(negedge clk);
        a = 8'h56; b = 8'h21; sub = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1; a = 8'h99; b = 8'h11; sub = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_sum", sum, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1 check("rst_mid_in_ready", in_ready, 1);
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mid_never_out", seen, 0);

        // Random traffic against the scoreboard.
        q.delete();
        n_in  = 0;
        n_out = 0;
        held  = 1'b0;
        held_val = '0;
        for (int cyc = 0; cyc < 60000 && (n_in < 10000 || n_out < 10000); cyc++) begin
            @(negedge clk);
            if (held) begin
                check("rand_hold_valid", out_valid, 1);
                check("rand_hold_data", {overflow, zero, carryout, sum}, held_val);
            end
            in_valid  = (n_in < 10000) && ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious_out", out_valid, 0);
                end else begin
                    exp_v = q.pop_front();
                    check("rand_result", {overflow, zero, carryout, sum}, exp_v);
                end
                n_out++;
            end
            held     = out_valid && !out_ready;
            held_val = {overflow, zero, carryout, sum};
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, sub));
                n_in++;
            end
        end
        check("rand_n_in", n_in, 10000);
        check("rand_n_out", n_out, n_in);
        check("rand_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (>= 2).
REQ-002 Parameter STAGES, default 4, number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES (CHUNK = WIDTH/STAGES bits per stage).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers an operation this cycle.
REQ-006 in_ready  output  1  block accepts the offered operation this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 sub  input  1  0 = a+b, 1 = a-b.
REQ-010 out_valid  output  1  result fields hold a completed operation.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 carryout  output  1  carry out of MSB; for subtraction 1 = no borrow.
REQ-014 overflow  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  sum == 0.

Function
REQ-016 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-017 Pipeline SHALL advance (all stages shift one step) when advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally.
REQ-018 When the pipeline does not advance, every stage register, including outputs, SHALL hold its value.
REQ-019 Each stage SHALL carry a valid bit; a bubble (no input transfer while advancing) SHALL enter stage 0 with valid = 0.
REQ-020 Latency SHALL be exactly STAGES advancing cycles from input transfer to out_valid = 1 for that operation; throughput one operation per cycle with no stall.
REQ-021 On accept, b SHALL be bitwise inverted and carry-in set to 1 when sub = 1; otherwise b unchanged, carry-in 0.
REQ-022 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] of a and (modified) b plus the carry from stage k-1 (stage 0: initial carry-in), forwarding completed lower chunks, unused upper operand chunks, and its chunk carry-out.
REQ-023 carryout SHALL be the carry out of the last chunk; overflow SHALL be (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), b' = modified b.
REQ-024 zero SHALL be registered with the final stage, not computed from sum combinationally at the output.
REQ-025 Operations SHALL emerge in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-026 Simultaneous input and output transfer in the same cycle SHALL be supported with the pipeline full.
REQ-027 Outputs with out_valid = 0 carry no meaning; a stalled out_valid = 1 result SHALL remain stable until consumed.

Reset
REQ-028 While reset = 1 at a rising edge, all stage valid bits SHALL clear; sum, carryout, overflow, zero SHALL clear to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; out_valid = 0 from the next cycle; in_ready = 1 once reset deasserts.
REQ-030 An input offered in the same cycle reset is high SHALL NOT be accepted.

Structure
REQ-031 Package adder_pkg SHALL hold OP_ADD = 1'b0, OP_SUB = 1'b1 and the CHUNK derivation helper; no other shared typedefs.
REQ-032 One sub-module, adder_chunk (parametrised CHUNK-bit ripple adder: a, b, carryin -> sum, carryout, generate/propagate per bit), SHALL be instantiated once per stage.

Verification (WIDTH = 8, STAGES = 4)
REQ-033 add 8'hFF + 8'h01, out_ready = 1 -> after 4 cycles sum 8'h00, carryout 1, overflow 0, zero 1.
REQ-034 add 8'h7F + 8'h01 -> sum 8'h80, carryout 0, overflow 1, zero 0; sub 8'h80 - 8'h01 -> sum 8'h7F, carryout 1, overflow 1.
REQ-035 sub 8'h05 - 8'h05 -> sum 8'h00, carryout 1, zero 1; sub 8'h03 - 8'h05 -> sum 8'hFE, carryout 0, overflow 0.
REQ-036 Six back-to-back ops, out_ready low for 3 cycles once first result valid -> in_ready low during stall, held result stable, all six results in order, none lost.
REQ-037 Reset asserted 2 cycles after accepting 2 ops -> out_valid 0 next cycle, neither op ever appears at output.
REQ-038 Random 10,000 ops, random in_valid/out_ready -> every result matches {carryout, sum} = a + b' + cin reference, count in = count out.
